// File: rtl/trdb_pkg.sv
// Shared definitions for the trace trigger block: FSM state encoding,
// config register map and CTRL bit positions.
package trdb_pkg;

  // Trigger FSM states; the encoding is visible on state_o and in CTRL[5:4]
  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_ARMED   = 2'd1,
    T_TRACING = 2'd2
  } trigger_state_e;

  // Config register map (cfg_addr_i)
  localparam logic [1:0] CFG_START  = 2'd0;
  localparam logic [1:0] CFG_STOP   = 2'd1;
  localparam logic [1:0] CFG_CTRL   = 2'd2;
  localparam logic [1:0] CFG_WINDOW = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ARM      = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_WIN_EN   = 2;
  localparam int CTRL_STATE_LO = 4;
  localparam int CTRL_STATE_HI = 5;

endpackage

// File: rtl/trdb_trigger.sv
// Trace start/stop controller. Compares retired instruction addresses against
// programmable START/STOP addresses and an optional instruction-count window,
// and drives the trace-on pulse and trace-off level for the register block.
module trdb_trigger
  import trdb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic            cfg_re_i,
  input  logic [1:0]      cfg_addr_i,
  input  logic [XLEN-1:0] cfg_wdata_i,
  output logic [XLEN-1:0] cfg_rdata_o,
  input  logic            ivalid_i,
  input  logic [XLEN-1:0] iaddr_i,
  output logic            trace_req_on_o,
  output logic            trace_req_off_o,
  output logic [1:0]      state_o
);

  logic [XLEN-1:0]  r_start;
  logic [XLEN-1:0]  r_stop;
  logic [XLEN-1:0]  r_window;
  logic             r_arm;
  logic             r_oneshot;
  logic             r_winEn;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rdata;
  logic             r_on;
  logic             r_off;
  trigger_state_e   r_state;

  trigger_state_e   w_nextState;
  logic             w_startHit;
  logic             w_stopHit;
  logic             w_winHit;
  logic [CNT_W-1:0] w_winLimit;
  logic [CNT_W-1:0] w_cntInc;
  logic             w_ctrlWrite;
  logic             w_disarm;
  logic             w_hwDisarm;
  logic [XLEN-1:0]  w_ctrlView;
  logic [XLEN-1:0]  w_rdMux;

  // Address comparators, window detection and decoded config strobes
  always_comb begin
    w_startHit  = ivalid_i && (iaddr_i == r_start);
    w_stopHit   = ivalid_i && (iaddr_i == r_stop);
    w_winLimit  = r_window[CNT_W-1:0];
    w_cntInc    = r_cnt + CNT_W'(1);
    w_winHit    = ivalid_i && r_winEn && (w_winLimit != '0) && (w_cntInc == w_winLimit);
    w_ctrlWrite = cfg_we_i && (cfg_addr_i == CFG_CTRL);
    w_disarm    = w_ctrlWrite && !cfg_wdata_i[CTRL_ARM];
  end

  // Next-state logic; a software disarm (or a cleared arm bit) always wins
  // over a match so no spurious on-pulse can follow a disarm
  always_comb begin
    w_nextState = r_state;
    w_hwDisarm  = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (r_arm && !w_disarm) w_nextState = T_ARMED;
      end
      T_ARMED: begin
        if (w_disarm || !r_arm) w_nextState = T_IDLE;
        else if (w_startHit)    w_nextState = T_TRACING;
      end
      T_TRACING: begin
        if (w_disarm || !r_arm) begin
          w_nextState = T_IDLE;
        end else if (w_stopHit || w_winHit) begin
          w_nextState = r_oneshot ? T_IDLE : T_ARMED;
          w_hwDisarm  = r_oneshot;
        end
      end
      default: w_nextState = T_IDLE;
    endcase
  end

  // State register plus registered on-pulse and off-level outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= T_IDLE;
      r_on    <= 1'b0;
      r_off   <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_on    <= (r_state == T_ARMED) && (w_nextState == T_TRACING);
      r_off   <= (w_nextState != T_TRACING);
    end
  end

  // Window counter: cleared on trace entry, counts retirements while tracing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if ((r_state == T_ARMED) && (w_nextState == T_TRACING)) begin
      r_cnt <= '0;
    end else if ((r_state == T_TRACING) && ivalid_i) begin
      r_cnt <= w_cntInc;
    end
  end

  // Config registers; a oneshot exit clears arm unless software writes CTRL
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_start   <= '0;
      r_stop    <= '0;
      r_window  <= '0;
      r_arm     <= 1'b0;
      r_oneshot <= 1'b0;
      r_winEn   <= 1'b0;
    end else begin
      if (cfg_we_i && (cfg_addr_i == CFG_START))  r_start  <= cfg_wdata_i;
      if (cfg_we_i && (cfg_addr_i == CFG_STOP))   r_stop   <= cfg_wdata_i;
      if (cfg_we_i && (cfg_addr_i == CFG_WINDOW)) r_window <= cfg_wdata_i;
      if (w_ctrlWrite) begin
        r_arm     <= cfg_wdata_i[CTRL_ARM];
        r_oneshot <= cfg_wdata_i[CTRL_ONESHOT];
        r_winEn   <= cfg_wdata_i[CTRL_WIN_EN];
      end else if (w_hwDisarm) begin
        r_arm     <= 1'b0;
      end
    end
  end

  // Read mux; CTRL exposes the live FSM state in its read-only field
  always_comb begin
    w_ctrlView                              = '0;
    w_ctrlView[CTRL_ARM]                    = r_arm;
    w_ctrlView[CTRL_ONESHOT]                = r_oneshot;
    w_ctrlView[CTRL_WIN_EN]                 = r_winEn;
    w_ctrlView[CTRL_STATE_HI:CTRL_STATE_LO] = r_state;
    case (cfg_addr_i)
      CFG_START:  w_rdMux = r_start;
      CFG_STOP:   w_rdMux = r_stop;
      CFG_CTRL:   w_rdMux = w_ctrlView;
      default:    w_rdMux = r_window;
    endcase
  end

  // Read data register: loads on a read strobe, holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_rdata <= '0;
    else if (cfg_re_i) r_rdata <= w_rdMux;
  end

  assign cfg_rdata_o     = r_rdata;
  assign trace_req_on_o  = r_on;
  assign trace_req_off_o = r_off;
  assign state_o         = r_state;

endmodule
